// File: rtl/chord_if_fifo.sv
// chord_if_fifo: first-word-fall-through word FIFO between the bus write path
// and the execution consumer. It provides the fill level, full and almost-full
// levels, and sticky overflow and underflow flags for back-pressure.
//
// Handshake semantics: neither side has a ready signal.
// - A push (wr_valid) is accepted when the FIFO is not full. It is also
//   accepted when the FIFO is full and a pop on the same edge frees a slot.
//   Otherwise the word is dropped and overflow is set.
// - A pop (read_fifo_en) is accepted when the FIFO is not empty. Otherwise it
//   is ignored and underflow is set.
// - The head word is valid on out_fifo whenever empty is 0.
module chord_if_fifo #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read_fifo_en,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] out_fifo,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_C = AFULL_TH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic push_ok;
    logic pop_ok;
    logic ovf_set;
    logic udf_set;

    // Level flags come straight from the count register, so they have no extra lag.
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AFULL_C);

    // A pop while full frees the slot that this push overwrites. The slot's
    // old word is the head, which leaves the FIFO on the same edge.
    assign push_ok = wr_valid && (!full || read_fifo_en);
    assign pop_ok  = read_fifo_en && !empty;
    assign ovf_set = wr_valid && full && !read_fifo_en;
    assign udf_set = read_fifo_en && empty;

    // First-word-fall-through head. It is forced to zero while empty so that
    // stale storage never shows.
    assign out_fifo = empty ? '0 : mem[rd_ptr];

    // Storage write. No reset is needed because contents are only visible
    // through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and count. The pointers wrap naturally at DEPTH. The count is
    // kept as its own register so that full and empty are never ambiguous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. A new error on the same edge as clr_flags keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow && !clr_flags);
            underflow <= udf_set || (underflow && !clr_flags);
        end
    end

endmodule

// File: tb/tb_chord_if_fifo.sv
// Testbench for chord_if_fifo. A table of single-edge vectors covers reset,
// basic push/pop, and flag behaviour. Hand-written sequences backed by a
// queue model cover the fill, overflow, wrap and mid-operation reset cases.
module tb_chord_if_fifo;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        read_fifo_en;
    logic        clr_flags;
    logic [31:0] out_fifo;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int tests;
    int fails;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rd;
        logic        clr;
        logic [31:0] e_out;
        logic        e_empty;
        logic        e_full;
        logic        e_af;
        logic [4:0]  e_cnt;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    chord_if_fifo #(.DATA_W(32), .ADDR_W(4), .AFULL_TH(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .read_fifo_en (read_fifo_en),
        .clr_flags    (clr_flags),
        .out_fifo     (out_fifo),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic wv, input logic [31:0] wd, input logic rd, input logic clr);
        wr_valid     = wv;
        wr_data      = wd;
        read_fifo_en = rd;
        clr_flags    = clr;
        @(posedge clk);
        #1;
    endtask

    // Apply one operation, update the queue model, and compare the level outputs and the head word.
    task automatic do_op(input string name, input logic wv, input logic [31:0] wd, input logic rd);
        int  pre;
        bit  push_ok;
        bit  pop_ok;
        pre     = exp_q.size();
        push_ok = wv && (pre < 16 || rd);
        pop_ok  = rd && (pre > 0);
        step(wv, wd, rd, 1'b0);
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(wd);
        check({name, ".count"}, 32'(count), 32'(exp_q.size()));
        check({name, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({name, ".full"}, 32'(full), 32'(exp_q.size() == 16));
        check({name, ".afull"}, 32'(almost_full), 32'(exp_q.size() >= 12));
        check({name, ".out"}, out_fifo, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        wr_valid     = 1'b0;
        wr_data      = '0;
        read_fifo_en = 1'b0;
        clr_flags    = 1'b0;

        //            wv  wd            rd  clr  out           emp  ful  af   cnt  ovf  udf
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hA5A50001, 1'b0, 1'b0, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h55,       1'b1, 1'b0, 32'h55,       1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h55,       1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h11,       1'b0, 1'b0, 32'h11,       1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h22,       1'b0, 1'b0, 32'h11,       1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h33,       1'b1, 1'b0, 32'h22,       1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h33,       1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state before any edge is taken after release
        check("rst.empty", 32'(empty), 32'h1);
        check("rst.count", 32'(count), 32'h0);
        check("rst.out", out_fifo, 32'h0);
        check("rst.ovf", 32'(overflow), 32'h0);
        check("rst.udf", 32'(underflow), 32'h0);

        // Table-driven single-edge vectors
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].wv, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            check($sformatf("v%0d.out", i), out_fifo, vecs[i].e_out);
            check($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
            check($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("v%0d.afull", i), 32'(almost_full), 32'(vecs[i].e_af));
            check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d.udf", i), 32'(underflow), 32'(vecs[i].e_udf));
        end

        // Fill to 16, then a dropped 17th push and a full drain in order
        exp_q.delete();
        for (int i = 0; i < 16; i++) do_op($sformatf("fill%0d", i), 1'b1, 32'h100 + i, 1'b0);
        do_op("drop", 1'b1, 32'hDEAD, 1'b0);
        check("drop.ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) do_op($sformatf("drain%0d", i), 1'b0, 32'h0, 1'b1);
        check("drain.ovf_sticky", 32'(overflow), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("clr.ovf", 32'(overflow), 32'h0);

        // A push and a pop on the same edge while full, then drain so 0x200 comes out last
        for (int i = 0; i < 16; i++) do_op($sformatf("refill%0d", i), 1'b1, 32'h180 + i, 1'b0);
        do_op("fullpp", 1'b1, 32'h200, 1'b1);
        check("fullpp.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 15; i++) do_op($sformatf("d2_%0d", i), 1'b0, 32'h0, 1'b1);
        check("last_is_200", out_fifo, 32'h200);
        do_op("d2_last", 1'b0, 32'h0, 1'b1);

        // Simultaneous push and pop across 40 edges while full, so the pointers wrap
        for (int i = 0; i < 16; i++) do_op($sformatf("f3_%0d", i), 1'b1, 32'h280 + i, 1'b0);
        for (int i = 0; i < 40; i++) do_op($sformatf("wrap%0d", i), 1'b1, 32'h300 + i, 1'b1);
        check("wrap.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 16; i++) do_op($sformatf("d3_%0d", i), 1'b0, 32'h0, 1'b1);

        // Reset asserted between edges with 9 words stored
        for (int i = 0; i < 9; i++) do_op($sformatf("f4_%0d", i), 1'b1, 32'h400 + i, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst.empty", 32'(empty), 32'h1);
        check("midrst.count", 32'(count), 32'h0);
        check("midrst.out", out_fifo, 32'h0);
        #1 reset = 1'b0;
        exp_q.delete();
        do_op("post_rst", 1'b1, 32'h7, 1'b0);
        check("post_rst.out7", out_fifo, 32'h7);

        step(1'b0, 32'h0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
